// File: rtl/tdm_demux_4to1_if.sv
// tdm_demux_4to1_if: serial TDM input and buffered parallel word output of the 4:1 demux
interface tdm_demux_4to1_if #(
  parameter int LANES = 4,
  parameter int SEL_W = $clog2(LANES)
);
  logic             i_bit;
  logic             i_bit_valid;
  logic             i_sync;
  logic             i_ready;
  logic [SEL_W-1:0] o_sel;
  logic [LANES-1:0] o_data;
  logic             o_valid;
  logic             o_overrun;
  logic             o_sync_err;
  modport master (
    output i_bit, i_bit_valid, i_sync, i_ready,
    input  o_sel, o_data, o_valid, o_overrun, o_sync_err
  );
  modport slave (
    input  i_bit, i_bit_valid, i_sync, i_ready,
    output o_sel, o_data, o_valid, o_overrun, o_sync_err
  );
endinterface

// File: rtl/tdm_demux_4to1.sv
// tdm_demux_4to1: tracks TDM slots, routes serial bits to lanes, and buffers reassembled words
module tdm_demux_4to1 #(
  parameter int LANES = 4,
  parameter int SEL_W = $clog2(LANES)
) (
  input logic              i_clk,
  input logic              i_rst_n,
  tdm_demux_4to1_if.slave  bus
);
  typedef enum logic {HUNT, COLLECT} state_t;
  state_t           state, state_nx;
  logic [SEL_W-1:0] slot, slot_nx;
  logic [LANES-1:0] lanes, lanes_nx, word, data, data_nx;
  logic             valid, valid_nx, overrun, overrun_nx, sync_err, sync_err_nx, done;
  always_comb begin
    state_nx    = state;
    slot_nx     = slot;
    lanes_nx    = lanes;
    sync_err_nx = sync_err;
    done        = 1'b0;
    word        = lanes;
    word[slot]  = bus.i_bit;
    // a sync in HUNT, or a misplaced sync mid-frame, restarts the frame at lane 0
    if (bus.i_bit_valid) begin
      if (bus.i_sync && (state == HUNT || slot != '0)) begin
        state_nx    = COLLECT;
        slot_nx     = SEL_W'(1);
        lanes_nx    = LANES'(bus.i_bit);
        sync_err_nx = sync_err | (state == COLLECT);
      end else if (state == COLLECT) begin
        lanes_nx = word;
        done     = slot == SEL_W'(LANES - 1);
        slot_nx  = done ? '0 : slot + SEL_W'(1);
      end
    end
    data_nx    = data;
    valid_nx   = valid & ~bus.i_ready;
    overrun_nx = overrun;
    if (done) begin
      if (!valid || bus.i_ready) begin
        data_nx  = word;
        valid_nx = 1'b1;
      end else begin
        overrun_nx = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= HUNT;
      slot     <= '0;
      lanes    <= '0;
      data     <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nx;
      slot     <= slot_nx;
      lanes    <= lanes_nx;
      data     <= data_nx;
      valid    <= valid_nx;
      overrun  <= overrun_nx;
      sync_err <= sync_err_nx;
    end
  end
  assign bus.o_sel      = slot;
  assign bus.o_data     = data;
  assign bus.o_valid    = valid;
  assign bus.o_overrun  = overrun;
  assign bus.o_sync_err = sync_err;
endmodule
